// File: rtl/evm_seq_pkg.sv
// Shared types, status codes and opcode helpers
// for the EVM fetch/step sequencer.
package evm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_WAIT_OP,
    S_FETCH_IMM,
    S_WAIT_IMM,
    S_EXEC,
    S_CHECK,
    S_HALT
  } state_t;

  localparam logic [2:0] ST_NONE  = 3'd0;
  localparam logic [2:0] ST_EXIT  = 3'd1;
  localparam logic [2:0] ST_OOG   = 3'd2;
  localparam logic [2:0] ST_EOC   = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  localparam logic [7:0] PUSH1  = 8'h60;
  localparam logic [7:0] PUSH32 = 8'h7F;

  localparam int IMM_W = 256;

  // PUSHn carries n immediate bytes; n = opcode - 0x5F.
  function automatic logic [5:0] push_len(
    input logic [7:0] op
  );
    if (op >= PUSH1 && op <= PUSH32)
      return 6'(op[4:0]) + 6'd1;
    return 6'd0;
  endfunction

endpackage

// File: rtl/evm_imm_shifter.sv
// PUSH immediate assembly: 256-bit big-endian
// shift register plus remaining-byte counter.
module evm_imm_shifter
  import evm_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [5:0]       cnt_in,
  input  logic             shift,
  input  logic [7:0]       byte_in,
  output logic [IMM_W-1:0] code_data,
  output logic [5:0]       imm_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      code_data <= '0;
      imm_cnt   <= '0;
    end else if (clr) begin
      code_data <= '0;
      imm_cnt   <= cnt_in;
    end else if (shift && imm_cnt != 6'd0) begin
      code_data <= {code_data[IMM_W-9:0], byte_in};
      imm_cnt   <= imm_cnt - 6'd1;
    end
  end

endmodule

// File: rtl/evm_sequencer.sv
// Fetch/step controller: reads opcode and PUSH bytes,
// pulses exec_step, then checks gas and exit.
module evm_sequencer
  import evm_seq_pkg::*;
#(
  parameter int CODE_AW = 16,
  parameter int GAS_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CODE_AW-1:0] code_len,
  input  logic [GAS_W-1:0]   gas_limit,
  output logic               code_rd_en,
  output logic [CODE_AW-1:0] code_addr,
  input  logic               code_rd_valid,
  input  logic [7:0]         code_rd_data,
  output logic [7:0]         opcode,
  output logic [255:0]       code_data,
  output logic               exec_step,
  input  logic [CODE_AW-1:0] pc_i,
  input  logic [GAS_W-1:0]   gas_i,
  input  logic               exit_i,
  output logic               busy,
  output logic               done,
  output logic [2:0]         status
);

  state_t             state;
  logic [CODE_AW-1:0] len_q;
  logic [GAS_W-1:0]   gas_lim;
  logic               past_end;
  logic [5:0]         imm_cnt;

  logic               sh_clr;
  logic               sh_shift;
  logic [5:0]         sh_cnt;
  logic [7:0]         sh_byte;

  logic [CODE_AW-1:0] nxt_addr;
  logic               op_past;
  logic               nxt_past;
  logic               last_byte;
  logic               kill;

  assign nxt_addr  = code_addr + CODE_AW'(1);
  assign op_past   = (nxt_addr >= len_q) ||
                     (nxt_addr == '0);
  assign nxt_past  = past_end || op_past;
  assign last_byte = (imm_cnt == 6'd1);
  assign kill      = abort && busy;

  always_comb begin
    sh_clr   = 1'b0;
    sh_shift = 1'b0;
    sh_byte  = 8'h00;
    sh_cnt   = push_len(code_rd_data);
    if (!kill) begin
      unique case (state)
        S_WAIT_OP: sh_clr = code_rd_valid;
        S_FETCH_IMM: sh_shift = past_end;
        S_WAIT_IMM: begin
          sh_shift = code_rd_valid;
          sh_byte  = code_rd_data;
        end
        default: ;
      endcase
    end
  end

  evm_imm_shifter u_imm (
    .clk       (clk),
    .rst       (rst),
    .clr       (sh_clr),
    .cnt_in    (sh_cnt),
    .shift     (sh_shift),
    .byte_in   (sh_byte),
    .code_data (code_data),
    .imm_cnt   (imm_cnt)
  );

  // code_rd_en is decided on the way into a fetch
  // state so the request is visible in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      code_rd_en <= 1'b0;
      code_addr  <= '0;
      opcode     <= '0;
      exec_step  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= ST_NONE;
      len_q      <= '0;
      gas_lim    <= '0;
      past_end   <= 1'b0;
    end else begin
      code_rd_en <= 1'b0;
      exec_step  <= 1'b0;
      if (kill) begin
        state  <= S_HALT;
        busy   <= 1'b0;
        done   <= 1'b1;
        status <= ST_ABORT;
      end else begin
        unique case (state)
          S_IDLE, S_HALT: begin
            if (start) begin
              len_q      <= code_len;
              gas_lim    <= gas_limit;
              status     <= ST_NONE;
              done       <= 1'b0;
              busy       <= 1'b1;
              code_addr  <= pc_i;
              code_rd_en <= pc_i < code_len;
              state      <= S_FETCH_OP;
            end
          end
          S_FETCH_OP: begin
            if (code_rd_en) begin
              state <= S_WAIT_OP;
            end else begin
              state  <= S_HALT;
              busy   <= 1'b0;
              done   <= 1'b1;
              status <= ST_EOC;
            end
          end
          S_WAIT_OP: begin
            if (code_rd_valid) begin
              opcode    <= code_rd_data;
              code_addr <= nxt_addr;
              past_end  <= op_past;
              if (sh_cnt != 6'd0) begin
                state      <= S_FETCH_IMM;
                code_rd_en <= !op_past;
              end else begin
                state     <= S_EXEC;
                exec_step <= 1'b1;
              end
            end
          end
          S_FETCH_IMM: begin
            if (!past_end) begin
              state <= S_WAIT_IMM;
            end else begin
              code_addr <= nxt_addr;
              if (last_byte) begin
                state     <= S_EXEC;
                exec_step <= 1'b1;
              end
            end
          end
          S_WAIT_IMM: begin
            if (code_rd_valid) begin
              code_addr <= nxt_addr;
              past_end  <= nxt_past;
              if (last_byte) begin
                state     <= S_EXEC;
                exec_step <= 1'b1;
              end else begin
                state      <= S_FETCH_IMM;
                code_rd_en <= !nxt_past;
              end
            end
          end
          S_EXEC: state <= S_CHECK;
          S_CHECK: begin
            if (gas_i > gas_lim) begin
              state  <= S_HALT;
              busy   <= 1'b0;
              done   <= 1'b1;
              status <= ST_OOG;
            end else if (exit_i) begin
              state  <= S_HALT;
              busy   <= 1'b0;
              done   <= 1'b1;
              status <= ST_EXIT;
            end else begin
              state      <= S_FETCH_OP;
              code_addr  <= pc_i;
              code_rd_en <= pc_i < len_q;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_evm_sequencer.sv
// Directed bench for evm_sequencer with a latency-
// configurable code memory and a small datapath model.
module tb_evm_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [15:0]  code_len;
  logic [31:0]  gas_limit;
  logic         code_rd_en;
  logic [15:0]  code_addr;
  logic         code_rd_valid = 1'b0;
  logic [7:0]   code_rd_data = 8'h00;
  logic [7:0]   opcode;
  logic [255:0] code_data;
  logic         exec_step;
  logic         busy;
  logic         done;
  logic [2:0]   status;

  logic [15:0]  dp_pc = '0;
  logic [31:0]  dp_gas = '0;
  logic         dp_exit = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0]   mem [0:63];
  int           lat;
  int           gas_step;
  logic         exit_on_stop;
  logic         mclr;

  int           cyc = 0;
  int           reads = 0;
  int           overlap = 0;
  int           steps = 0;
  int           cnt = 0;
  logic         outst = 1'b0;
  logic [15:0]  raddr = '0;
  logic [7:0]   st_op [0:7];
  logic [255:0] st_data [0:7];
  int           st_cyc [0:7];

  always #5 clk = ~clk;

  evm_sequencer #(.CODE_AW(16), .GAS_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .code_len      (code_len),
    .gas_limit     (gas_limit),
    .code_rd_en    (code_rd_en),
    .code_addr     (code_addr),
    .code_rd_valid (code_rd_valid),
    .code_rd_data  (code_rd_data),
    .opcode        (opcode),
    .code_data     (code_data),
    .exec_step     (exec_step),
    .pc_i          (dp_pc),
    .gas_i         (dp_gas),
    .exit_i        (dp_exit),
    .busy          (busy),
    .done          (done),
    .status        (status)
  );

  function automatic int plen(input logic [7:0] op);
    if (op >= 8'h60 && op <= 8'h7F) return int'(op) - 95;
    return 0;
  endfunction

  // Code memory (lat cycles) and datapath model.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    code_rd_valid <= 1'b0;
    if (mclr) begin
      reads   <= 0;
      overlap <= 0;
      outst   <= 1'b0;
      cnt     <= 0;
      steps   <= 0;
      dp_pc   <= '0;
      dp_gas  <= '0;
      dp_exit <= 1'b0;
    end else begin
      if (cnt == 1) begin
        code_rd_valid <= 1'b1;
        code_rd_data  <= mem[raddr[5:0]];
        outst <= 1'b0;
      end
      if (cnt > 0) cnt <= cnt - 1;
      if (code_rd_en) begin
        reads <= reads + 1;
        if (outst) overlap <= overlap + 1;
        if (lat <= 1) begin
          code_rd_valid <= 1'b1;
          code_rd_data  <= mem[code_addr[5:0]];
        end else begin
          outst <= 1'b1;
          raddr <= code_addr;
          cnt   <= lat - 1;
        end
      end
      if (exec_step) begin
        if (steps < 8) begin
          st_op[steps]   <= opcode;
          st_data[steps] <= code_data;
          st_cyc[steps]  <= cyc;
        end
        steps  <= steps + 1;
        dp_pc  <= dp_pc + 16'd1 + 16'(plen(opcode));
        dp_gas <= dp_gas + 32'(gas_step);
        if (exit_on_stop && opcode == 8'h00)
          dp_exit <= 1'b1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_model;
    mclr = 1'b1;
    tick;
    mclr = 1'b0;
  endtask

  task automatic clr_mem;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
  endtask

  task automatic go(input logic [15:0] len,
                    input logic [31:0] lim);
    code_len  = len;
    gas_limit = lim;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      tick;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles",
               name, done, n);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({code_rd_en, code_addr, opcode, exec_step,
         busy, done, status} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: rd_en=%0b addr=%0h op=%0h step=%0b busy=%0b done=%0b st=%0d want all 0",
               code_rd_en, code_addr, opcode, exec_step,
               busy, done, status);
    end
    checks++;
    if (code_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", code_data);
    end
  endtask

  task automatic test_push_exit;
    clr_mem;
    mem[0] = 8'h60; mem[1] = 8'hAB; mem[2] = 8'h00;
    lat = 1; exit_on_stop = 1'b1; gas_step = 1;
    clr_model;
    go(16'd3, 32'hFFFF_FFFF);
    wait_done("t1");
    checks++;
    if (steps !== 2) begin
      errors++;
      $display("FAIL t1_steps: got %0d want 2", steps);
    end
    checks++;
    if (st_op[0] !== 8'h60 || st_data[0] !== 256'hAB) begin
      errors++;
      $display("FAIL t1_step0: op=%h data=%h want 60/ab",
               st_op[0], st_data[0]);
    end
    checks++;
    if (st_op[1] !== 8'h00 || st_data[1] !== 256'h0) begin
      errors++;
      $display("FAIL t1_step1: op=%h data=%h want 00/0",
               st_op[1], st_data[1]);
    end
    checks++;
    if (status !== 3'd1 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_halt: st=%0d done=%0b busy=%0b want 1/1/0",
               status, done, busy);
    end
    checks++;
    if (reads !== 3) begin
      errors++;
      $display("FAIL t1_reads: got %0d want 3", reads);
    end
    checks++;
    if (st_cyc[1] - st_cyc[0] !== 4) begin
      errors++;
      $display("FAIL t1_latency: got %0d want 4",
               st_cyc[1] - st_cyc[0]);
    end
  endtask

  task automatic test_zero_fill;
    clr_mem;
    mem[0] = 8'h61; mem[1] = 8'h12; mem[2] = 8'hEE;
    lat = 1; exit_on_stop = 1'b0; gas_step = 1;
    clr_model;
    go(16'd2, 32'hFFFF_FFFF);
    wait_done("t2");
    checks++;
    if (steps !== 1 || st_op[0] !== 8'h61) begin
      errors++;
      $display("FAIL t2_step: steps=%0d op=%h want 1/61",
               steps, st_op[0]);
    end
    checks++;
    if (st_data[0] !== 256'h1200) begin
      errors++;
      $display("FAIL t2_imm: got %h want 1200", st_data[0]);
    end
    checks++;
    if (reads !== 2) begin
      errors++;
      $display("FAIL t2_reads: got %0d want 2", reads);
    end
    checks++;
    if (status !== 3'd3) begin
      errors++;
      $display("FAIL t2_status: got %0d want 3", status);
    end
  endtask

  task automatic test_gas;
    clr_mem;
    for (int i = 0; i < 8; i++) mem[i] = 8'h01;
    lat = 1; exit_on_stop = 1'b0; gas_step = 3;
    clr_model;
    go(16'd8, 32'd10);
    wait_done("t3a");
    checks++;
    if (steps !== 4 || status !== 3'd2) begin
      errors++;
      $display("FAIL t3_oog10: steps=%0d st=%0d want 4/2",
               steps, status);
    end
    checks++;
    if (st_cyc[1] - st_cyc[0] !== 4) begin
      errors++;
      $display("FAIL t3_latency: got %0d want 4",
               st_cyc[1] - st_cyc[0]);
    end
    clr_model;
    go(16'd8, 32'd12);
    wait_done("t3b");
    checks++;
    if (steps !== 5 || status !== 3'd2) begin
      errors++;
      $display("FAIL t3_oog12: steps=%0d st=%0d want 5/2",
               steps, status);
    end
  endtask

  task automatic test_push32_slow;
    logic [255:0] exp;
    exp = '0;
    clr_mem;
    mem[0] = 8'h7F;
    for (int i = 1; i <= 32; i++) begin
      mem[i] = 8'(i * 7 + 3);
      exp = {exp[247:0], mem[i]};
    end
    lat = 3; exit_on_stop = 1'b0; gas_step = 1;
    clr_model;
    go(16'd33, 32'hFFFF_FFFF);
    wait_done("t4");
    checks++;
    if (steps !== 1 || st_op[0] !== 8'h7F) begin
      errors++;
      $display("FAIL t4_step: steps=%0d op=%h want 1/7f",
               steps, st_op[0]);
    end
    checks++;
    if (st_data[0] !== exp) begin
      errors++;
      $display("FAIL t4_imm: got %h want %h", st_data[0], exp);
    end
    checks++;
    if (overlap !== 0 || reads !== 33) begin
      errors++;
      $display("FAIL t4_reads: overlap=%0d reads=%0d want 0/33",
               overlap, reads);
    end
    checks++;
    if (status !== 3'd3) begin
      errors++;
      $display("FAIL t4_status: got %0d want 3", status);
    end
  endtask

  task automatic test_abort;
    int n;
    clr_mem;
    mem[0] = 8'h60; mem[1] = 8'h55; mem[2] = 8'h00;
    lat = 3; exit_on_stop = 1'b1; gas_step = 1;
    clr_model;
    go(16'd3, 32'hFFFF_FFFF);
    n = 0;
    while (reads < 2 && n < 100) begin
      tick;
      n++;
    end
    checks++;
    if (reads < 2) begin
      errors++;
      $display("FAIL t5_imm_read: reads=%0d want 2", reads);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (status !== 3'd4 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_abort: st=%0d done=%0b busy=%0b want 4/1/0",
               status, done, busy);
    end
    repeat (4) tick;
    checks++;
    if (code_data !== '0 || opcode !== 8'h60 || steps !== 0) begin
      errors++;
      $display("FAIL t5_late: data=%h op=%h steps=%0d want 0/60/0",
               code_data, opcode, steps);
    end
    lat = 1;
    clr_model;
    go(16'd3, 32'hFFFF_FFFF);
    wait_done("t5");
    checks++;
    if (status !== 3'd1 || steps !== 2 || st_data[0] !== 256'h55) begin
      errors++;
      $display("FAIL t5_rerun: st=%0d steps=%0d imm=%h want 1/2/55",
               status, steps, st_data[0]);
    end
  endtask

  task automatic test_reset_mid_run;
    int n;
    int rd0;
    clr_mem;
    mem[0] = 8'h60; mem[1] = 8'hAB; mem[2] = 8'h00;
    lat = 3; exit_on_stop = 1'b1; gas_step = 1;
    clr_model;
    go(16'd3, 32'hFFFF_FFFF);
    n = 0;
    while (reads < 1 && n < 100) begin
      tick;
      n++;
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (!exec_step && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (exec_step !== 1'b1) begin
      errors++;
      $display("FAIL t6_exec: exec_step=%0b want 1", exec_step);
    end
    checks++;
    if (overlap !== 0 || reads !== 2) begin
      errors++;
      $display("FAIL t6_busy_start: overlap=%0d reads=%0d want 0/2",
               overlap, reads);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    rd0 = reads;
    checks++;
    if ({code_rd_en, code_addr, opcode, exec_step,
         busy, done, status} !== '0 || code_data !== '0) begin
      errors++;
      $display("FAIL t6_reset: op=%h data=%h step=%0b busy=%0b st=%0d want all 0",
               opcode, code_data, exec_step, busy, status);
    end
    repeat (6) tick;
    checks++;
    if (busy !== 1'b0 || reads !== rd0) begin
      errors++;
      $display("FAIL t6_idle: busy=%0b reads=%0d want 0/%0d",
               busy, reads, rd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    code_len = '0;
    gas_limit = '0;
    lat = 1;
    gas_step = 0;
    exit_on_stop = 1'b0;
    mclr = 1'b1;
    clr_mem;
    repeat (3) tick;
    test_reset;
    rst = 1'b0;
    mclr = 1'b0;
    tick;
    test_push_exit;
    test_zero_fill;
    test_gas;
    test_push32_slow;
    test_abort;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/evm_sequencer.md
Name: evm_sequencer

Overview:
- Fetch/step controller for the EVM execution datapath.
- Reads opcode and PUSH immediate bytes from a byte-wide code memory at the datapath program counter.
- Presents opcode plus a 256-bit immediate and issues a one-cycle step pulse, so the datapath advances exactly one instruction per step.
- Monitors the datapath's gas and exit after every step and halts with a status code. Sits between code memory and the execution datapath.

Parameters:
- CODE_AW, 16, code address / pc width
- GAS_W, 32, gas counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin run from current datapath pc; ignored while busy
- abort  in  1  force halt (status ABORT)
- code_len  in  CODE_AW  code size in bytes; sampled on start
- gas_limit  in  GAS_W  gas budget; sampled on start
- code_rd_en  out  1  code memory read request, single-cycle pulse
- code_addr  out  CODE_AW  read byte address
- code_rd_valid  in  1  read data valid; arrives ≥1 cycle after code_rd_en
- code_rd_data  in  8  read byte
- opcode  out  8  current opcode to datapath
- code_data  out  256  PUSH immediate, right-aligned big-endian; 0 for non-PUSH
- exec_step  out  1  one-cycle pulse: datapath executes opcode/code_data
- pc_i  in  CODE_AW  datapath pc, valid the cycle after exec_step
- gas_i  in  GAS_W  datapath cumulative gas
- exit_i  in  1  datapath halt request
- busy  out  1  run in progress
- done  out  1  high in HALT until next start
- status  out  3  0 NONE, 1 EXIT, 2 OUT_OF_GAS, 3 END_OF_CODE, 4 ABORT

Behaviour:
- Reset: state IDLE; code_rd_en=0, code_addr=0, opcode=0, code_data=0, exec_step=0, busy=0, done=0, status=0. Reset mid-run discards any outstanding read; a late code_rd_valid is ignored.
- States: IDLE, FETCH_OP, WAIT_OP, FETCH_IMM, WAIT_IMM, EXEC, CHECK, HALT.
- IDLE/HALT + start:
  - latch code_len and gas_limit; clear status and done; busy=1; go FETCH_OP.
  - start is ignored in all other states.
- FETCH_OP:
  - If pc_i ≥ code_len, go HALT with END_OF_CODE.
  - Otherwise pulse code_rd_en with code_addr=pc_i and go WAIT_OP.
- WAIT_OP, on code_rd_valid:
  - latch opcode; clear code_data; set imm_cnt.
  - imm_cnt = opcode−0x5F for 0x60..0x7F (PUSH1..PUSH32), else 0.
  - Go FETCH_IMM if imm_cnt≠0, else EXEC. Byte address counter = pc_i+1.
- FETCH_IMM:
  - If addr ≥ code_len (or addr wrapped to 0), shift in 0x00 without a read, stay in FETCH_IMM.
  - Otherwise pulse code_rd_en and go WAIT_IMM.
  - Each inserted byte: code_data ← {code_data[247:0], byte}; imm_cnt−1; addr+1. Move to EXEC when imm_cnt reaches 0.
- WAIT_IMM: on code_rd_valid, shift in code_rd_data as above; return to FETCH_IMM, or to EXEC if imm_cnt=0.
- Exactly one read is outstanding at any time. Address arithmetic is modulo 2^CODE_AW.
- EXEC: exec_step=1 for exactly one cycle; opcode/code_data held stable; go CHECK.
- CHECK (cycle after step), priority order:
  1. gas_i > gas_limit → OUT_OF_GAS (gas_i == gas_limit continues)
  2. exit_i → EXIT
  3. otherwise → FETCH_OP
- HALT: busy=0, done=1, status held. opcode/code_data keep last values.
- abort in any non-IDLE/HALT state → HALT with ABORT next cycle, takes priority over all other transitions. No exec_step in that cycle. Outstanding read data is dropped. abort in IDLE/HALT has no effect.
- Step latency: non-PUSH with 1-cycle memory = 4 cycles (FETCH_OP, WAIT_OP, EXEC, CHECK). PUSHn adds 2n cycles; each zero-filled byte adds 1 cycle.

Decomposition:
- Package evm_seq_pkg:
  - state enum
  - status codes
  - PUSH1=0x60, PUSH32=0x7F
  - function push_len(opcode) returning 0..32
- Sub-module evm_imm_shifter: 256-bit shift register with clear, shift-in byte, and remaining-byte counter. Owns code_data and imm_cnt.

Test Plan:
1. code_len=3, code {0x60,0xAB,0x00}; datapath model advances pc by 2 then 1 and asserts exit on opcode 0x00 → first step opcode 0x60, code_data=0x…00AB; second step opcode 0x00; status=EXIT, done=1, exec_step pulsed exactly twice.
2. code_len=2, code {0x61,0x12} → PUSH2 immediate is 0x1200 (missing byte zero-filled, no read issued at addr 2); next fetch at pc 3 → END_OF_CODE.
3. gas_limit=10; model adds 3 per step; 4 non-exit steps → halt after 4th step with OUT_OF_GAS (gas 12). Limit 12 allows the 4th step to continue.
4. PUSH32 with code_rd_valid delayed 3 cycles per read → all 32 bytes in order, code_data equals the 32 code bytes big-endian; never two reads outstanding.
5. abort asserted in WAIT_IMM, then valid arrives → status=ABORT next cycle, no exec_step, late byte ignored; a new start then runs normally.
6. rst asserted in EXEC, and start pulsed while busy → all outputs at reset values the cycle after rst; the start while busy is ignored.
